// File: rtl/banked_mem.sv
// banked_mem: banked 32-bit data memory for the load/store path.
// RISC-V byte/half/word loads and stores over a valid/ready request/response
// handshake. Loads take one cycle. A misaligned or illegal access still
// completes with o_fault=1. An optional zero-fill sweep runs after reset.
// Ports:
//   i_clk, i_reset        clock, synchronous active-high reset
//   i_req_valid/o_req_ready  request handshake
//   i_write, i_funct3, i_addr, i_din  request fields (store data right-aligned)
//   o_rsp_valid/i_rsp_ready  response handshake
//   o_dout, o_fault       extended load data (0 for stores/faults/idle), fault flag

// One bank: clock-enabled word RAM with byte write enables and a registered read.
module banked_mem_bank #(
    parameter int WORDS = 512,
    parameter int IW    = 9
) (
    input  logic          i_clk,
    input  logic          i_en,
    input  logic [3:0]    i_be,
    input  logic [IW-1:0] i_idx,
    input  logic [31:0]   i_wdata,
    output logic [31:0]   o_rdata
);
    logic [31:0] r_mem [WORDS];
    logic [31:0] r_rdata;

    always_ff @(posedge i_clk) begin
        if (i_en) begin
            for (int b = 0; b < 4; b++)
                if (i_be[b]) r_mem[i_idx][b*8 +: 8] <= i_wdata[b*8 +: 8];
            r_rdata <= r_mem[i_idx];
        end
    end

    assign o_rdata = r_rdata;
endmodule

module banked_mem #(
    parameter int NBANKS        = 4,
    parameter int BANK_WORDS    = 512,
    parameter int ADDR_W        = 13,
    parameter bit ZERO_ON_RESET = 1
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic              i_write,
    input  logic [2:0]        i_funct3,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [31:0]       i_din,
    output logic              o_rsp_valid,
    input  logic              i_rsp_ready,
    output logic [31:0]       o_dout,
    output logic              o_fault
);
    localparam int BW = $clog2(NBANKS);
    localparam int IW = $clog2(BANK_WORDS);

    typedef enum logic {S_INIT, S_RUN} state_t;

    state_t        r_state;
    logic [IW-1:0] r_cnt;
    logic          r_rsp_valid;
    logic [BW-1:0] r_bank;
    logic [1:0]    r_lane;
    logic [2:0]    r_f3;
    logic          r_write;
    logic          r_fault;

    logic                     w_accept;
    logic                     w_init;
    logic                     w_fault;
    logic [BW-1:0]            w_bank;
    logic [IW-1:0]            w_idx;
    logic [1:0]               w_lane;
    logic [3:0]               w_be;
    logic [31:0]              w_wdata;
    logic [NBANKS-1:0]        w_en;
    logic [NBANKS-1:0][31:0]  w_rdata;
    logic [31:0]              w_word;
    logic [7:0]               w_byte;
    logic [15:0]              w_half;

    assign w_init      = (r_state == S_INIT);
    assign o_req_ready = (r_state == S_RUN) && (!r_rsp_valid || i_rsp_ready);
    assign w_accept    = i_req_valid && o_req_ready;

    assign w_bank = i_addr[ADDR_W-1 -: BW];
    assign w_idx  = i_addr[ADDR_W-BW-1:2];
    assign w_lane = i_addr[1:0];

    // Alignment faults key off the width bits; funct3 legality differs by direction.
    always_comb begin
        w_fault = 1'b0;
        if (i_funct3[1:0] == 2'b01 && i_addr[0])        w_fault = 1'b1;
        if (i_funct3[1:0] == 2'b10 && i_addr[1:0] != 0) w_fault = 1'b1;
        if (i_write) begin
            if (i_funct3[2] || i_funct3[1:0] == 2'b11)  w_fault = 1'b1;
        end else begin
            if (i_funct3 == 3'b011 || i_funct3[2:1] == 2'b11) w_fault = 1'b1;
        end
    end

    // Store data is replicated across lanes so byte enables alone pick the target.
    always_comb begin
        w_be    = 4'b0000;
        w_wdata = i_din;
        if (w_init) begin
            w_be    = 4'b1111;
            w_wdata = 32'h0;
        end else if (i_write && !w_fault) begin
            case (i_funct3[1:0])
                2'b00: begin w_be = 4'b0001 << w_lane;           w_wdata = {4{i_din[7:0]}};  end
                2'b01: begin w_be = 4'b0011 << {w_lane[1], 1'b0}; w_wdata = {2{i_din[15:0]}}; end
                default: w_be = 4'b1111;
            endcase
        end
    end

    for (genvar b = 0; b < NBANKS; b++) begin : g_bank
        assign w_en[b] = w_init || (w_accept && w_bank == BW'(b));
        banked_mem_bank #(.WORDS(BANK_WORDS), .IW(IW)) u_bank (
            .i_clk   (i_clk),
            .i_en    (w_en[b]),
            .i_be    (w_be),
            .i_idx   (w_init ? r_cnt : w_idx),
            .i_wdata (w_wdata),
            .o_rdata (w_rdata[b])
        );
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= ZERO_ON_RESET ? S_INIT : S_RUN;
            r_cnt       <= '0;
            r_rsp_valid <= 1'b0;
            r_bank      <= '0;
            r_lane      <= '0;
            r_f3        <= '0;
            r_write     <= 1'b0;
            r_fault     <= 1'b0;
        end else begin
            if (w_init) begin
                r_cnt <= r_cnt + 1'b1;
                if (r_cnt == IW'(BANK_WORDS-1)) r_state <= S_RUN;
            end
            if (w_accept) begin
                r_rsp_valid <= 1'b1;
                r_bank      <= w_bank;
                r_lane      <= w_lane;
                r_f3        <= i_funct3;
                r_write     <= i_write;
                r_fault     <= w_fault;
            end else if (i_rsp_ready) begin
                r_rsp_valid <= 1'b0;
            end
        end
    end

    // Response formatting from the held bank read plus the fields captured at accept.
    assign w_word = w_rdata[r_bank];
    assign w_byte = w_word[r_lane*8 +: 8];
    assign w_half = r_lane[1] ? w_word[31:16] : w_word[15:0];

    always_comb begin
        o_dout = 32'h0;
        if (r_rsp_valid && !r_write && !r_fault) begin
            case (r_f3)
                3'b000:  o_dout = {{24{w_byte[7]}}, w_byte};
                3'b100:  o_dout = {24'h0, w_byte};
                3'b001:  o_dout = {{16{w_half[15]}}, w_half};
                3'b101:  o_dout = {16'h0, w_half};
                3'b010:  o_dout = w_word;
                default: o_dout = 32'h0;
            endcase
        end
    end

    assign o_rsp_valid = r_rsp_valid;
    assign o_fault     = r_rsp_valid && r_fault;
endmodule

// File: tb/tb_banked_mem.sv
module tb_banked_mem;
    logic        clk = 0;
    logic        rst;
    logic        req_valid, req_ready, wr, rsp_valid, rsp_ready, fault;
    logic [2:0]  f3;
    logic [12:0] addr;
    logic [31:0] din, dout;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    banked_mem #(.NBANKS(4), .BANK_WORDS(512), .ADDR_W(13), .ZERO_ON_RESET(1)) dut (
        .i_clk(clk), .i_reset(rst), .i_req_valid(req_valid), .o_req_ready(req_ready),
        .i_write(wr), .i_funct3(f3), .i_addr(addr), .i_din(din),
        .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready), .o_dout(dout), .o_fault(fault)
    );

    typedef struct {
        bit        wr;
        bit [2:0]  f3;
        bit [12:0] addr;
        bit [31:0] din;
        bit [31:0] exp_dout;
        bit        exp_fault;
        string     name;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic do_req(input bit w, input bit [2:0] f, input bit [12:0] a, input bit [31:0] d);
        int n = 0;
        req_valid = 1; wr = w; f3 = f; addr = a; din = d;
        while (!req_ready && n < 50) begin @(negedge clk); n++; end
        if (!req_ready) begin
            errors++; checks++;
            $display("FAIL req_timeout: req_ready stuck 0 addr 0x%04h", a);
        end
        @(posedge clk); #1;
        req_valid = 0;
        @(negedge clk);
    endtask

    // Counts cycles with req_ready low starting from the first post-reset cycle.
    task automatic count_init(input string name);
        int n = 0;
        while (!req_ready && n < 1000) begin n++; @(negedge clk); end
        chk(name, n, 512);
    endtask

    task automatic add(input bit w, input bit [2:0] f, input bit [12:0] a, input bit [31:0] d,
                       input bit [31:0] ed, input bit ef, input string nm);
        vec_t v;
        v.wr = w; v.f3 = f; v.addr = a; v.din = d; v.exp_dout = ed; v.exp_fault = ef; v.name = nm;
        vecs.push_back(v);
    endtask

    initial begin
        add(0, 3'b010, 13'h0000, 0, 32'h0, 0, "lw_0000_zero");
        add(0, 3'b010, 13'h0FFC, 0, 32'h0, 0, "lw_0ffc_zero");
        add(0, 3'b010, 13'h1FFC, 0, 32'h0, 0, "lw_1ffc_zero");
        add(1, 3'b010, 13'h1234, 32'h80FF7F01, 32'h0, 0, "sw_1234");
        add(0, 3'b000, 13'h1234, 0, 32'h00000001, 0, "lb_1234");
        add(0, 3'b000, 13'h1237, 0, 32'hFFFFFF80, 0, "lb_1237");
        add(0, 3'b100, 13'h1237, 0, 32'h00000080, 0, "lbu_1237");
        add(0, 3'b001, 13'h1236, 0, 32'hFFFF80FF, 0, "lh_1236");
        add(0, 3'b101, 13'h1236, 0, 32'h000080FF, 0, "lhu_1236");
        add(0, 3'b101, 13'h1234, 0, 32'h00007F01, 0, "lhu_1234");
        add(0, 3'b010, 13'h1234, 0, 32'h80FF7F01, 0, "lw_1234");
        add(1, 3'b010, 13'h0800, 32'hAABBCCDD, 32'h0, 0, "sw_0800");
        add(1, 3'b000, 13'h0801, 32'hFFFFFF11, 32'h0, 0, "sb_0801");
        add(1, 3'b001, 13'h0802, 32'hFFFF2233, 32'h0, 0, "sh_0802");
        add(0, 3'b010, 13'h0800, 0, 32'h223311DD, 0, "lw_0800_merged");
        add(0, 3'b010, 13'h0000, 0, 32'h0, 0, "lw_0000_bank0");
        add(0, 3'b010, 13'h0002, 0, 32'h0, 1, "lw_misalign");
        add(1, 3'b001, 13'h0003, 32'h5555, 32'h0, 1, "sh_misalign");
        add(0, 3'b011, 13'h1234, 0, 32'h0, 1, "load_f3_011");
        add(0, 3'b110, 13'h1234, 0, 32'h0, 1, "load_f3_110");
        add(0, 3'b001, 13'h1235, 0, 32'h0, 1, "lh_odd");
        add(1, 3'b100, 13'h0800, 32'h99999999, 32'h0, 1, "store_f3_100");
        add(1, 3'b010, 13'h0801, 32'h77777777, 32'h0, 1, "sw_misalign");
        add(0, 3'b010, 13'h0000, 0, 32'h0, 0, "lw_0000_after_fault");
        add(0, 3'b010, 13'h0800, 0, 32'h223311DD, 0, "lw_0800_after_fault");

        rst = 1; req_valid = 0; wr = 0; f3 = 0; addr = 0; din = 0; rsp_ready = 1;
        @(negedge clk); @(negedge clk);
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_dout", dout, 0);
        chk("reset_fault", fault, 0);
        chk("reset_req_ready", req_ready, 0);
        rst = 0;
        count_init("init_cycles");

        foreach (vecs[i]) begin
            do_req(vecs[i].wr, vecs[i].f3, vecs[i].addr, vecs[i].din);
            chk({vecs[i].name, "_valid"}, rsp_valid, 1);
            chk({vecs[i].name, "_dout"}, dout, vecs[i].exp_dout);
            chk({vecs[i].name, "_fault"}, fault, vecs[i].exp_fault);
        end

        // Back-to-back: store then dependent load, then another load, one per cycle.
        req_valid = 1; wr = 1; f3 = 3'b010; addr = 13'h1FFC; din = 32'hDEADBEEF;
        @(negedge clk);
        chk("b2b_ready1", req_ready, 1);
        wr = 0; din = 0;
        @(negedge clk);
        chk("b2b_load_valid", rsp_valid, 1);
        chk("b2b_load_dout", dout, 32'hDEADBEEF);
        f3 = 3'b000; addr = 13'h1237;
        @(negedge clk);
        chk("b2b_lb_dout", dout, 32'hFFFFFF80);
        req_valid = 0;
        @(negedge clk);
        chk("b2b_drain_valid", rsp_valid, 0);

        // Backpressure: hold the response, queue a second request.
        rsp_ready = 0;
        do_req(0, 3'b010, 13'h1234, 0);
        req_valid = 1; wr = 0; f3 = 3'b010; addr = 13'h0800;
        for (int k = 0; k < 5; k++) begin
            chk("bp_req_ready", req_ready, 0);
            chk("bp_dout", dout, 32'h80FF7F01);
            chk("bp_valid", rsp_valid, 1);
            @(negedge clk);
        end
        rsp_ready = 1;
        #1;
        chk("bp_release_ready", req_ready, 1);
        @(negedge clk);
        req_valid = 0;
        chk("bp_second_valid", rsp_valid, 1);
        chk("bp_second_dout", dout, 32'h223311DD);
        @(negedge clk);
        chk("bp_idle_valid", rsp_valid, 0);
        chk("bp_idle_dout", dout, 0);

        // Reset drops a pending response.
        rsp_ready = 0;
        do_req(0, 3'b010, 13'h0800, 0);
        chk("pend_valid", rsp_valid, 1);
        rst = 1;
        @(negedge clk);
        chk("pend_dropped", rsp_valid, 0);
        rst = 0; rsp_ready = 1;

        // Reset mid-sweep restarts from word 0.
        repeat (200) @(negedge clk);
        chk("midinit_not_ready", req_ready, 0);
        rst = 1;
        @(negedge clk);
        rst = 0;
        count_init("reinit_cycles");
        do_req(0, 3'b010, 13'h1234, 0);
        chk("reinit_lw_1234", dout, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
